// File: rtl/pgm_rom_ddr_loader.sv
`default_nettype none
// ============================================================================
// Module      : pgm_rom_ddr_loader
// Description : Packs the 16-bit hps_io download stream into 64-bit DDRAM
//               words and writes them through a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module pgm_rom_ddr_loader #(
  parameter logic [28:0] DDR_BASE     = 29'h0600_0000,
  parameter int          REGION_SHIFT = 24,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  input  logic        ddram_busy,
  output logic        ddram_we,
  output logic [28:0] ddram_addr,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  output logic [3:0]  ddram_burstcnt,
  output logic        load_done
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_dl;
  logic              r_rise_held;
  logic              r_done;
  logic [28:0]       r_asm_addr;
  logic [63:0]       r_asm_data;
  logic [7:0]        r_asm_be;
  logic              r_asm_valid;
  logic              r_pend;
  logic [28:0]       r_fa [FIFO_DEPTH];
  logic [63:0]       r_fd [FIFO_DEPTH];
  logic [7:0]        r_fb [FIFO_DEPTH];
  logic [c_PW-1:0]   r_wp;
  logic [c_PW-1:0]   r_rp;
  logic [c_CW-1:0]   r_count;

  logic              w_rise, w_fall, w_go, w_acc, w_match, w_lane3;
  logic [1:0]        w_lane;
  logic [28:0]       w_wa;
  logic [63:0]       w_mdata, w_ndata;
  logic [7:0]        w_mbe, w_nbe;
  logic              w_push, w_wr_en, w_pop, w_nempty, w_full;
  logic [28:0]       w_paddr;
  logic [63:0]       w_pdata;
  logic [7:0]        w_pbe;
  logic [28:0]       w_asm_addr_n;
  logic [63:0]       w_asm_data_n;
  logic [7:0]        w_asm_be_n;
  logic              w_asm_valid_n, w_pend_n;
  logic [c_CW-1:0]   w_count_n;
  logic              w_unused;

  assign w_unused = ^{ioctl_index[7:3], ioctl_addr[26:REGION_SHIFT], ioctl_addr[0]};

  assign w_rise  = ioctl_download & ~r_dl;
  assign w_fall  = ~ioctl_download & r_dl;
  assign w_go    = (r_state == S_IDLE) && (w_rise || r_rise_held);
  assign w_acc   = ioctl_wr && ioctl_download && (r_state == S_LOAD);
  assign w_lane  = ioctl_addr[2:1];
  assign w_lane3 = (w_lane == 2'd3);
  assign w_wa    = DDR_BASE
                 + (29'(ioctl_index[2:0]) << (REGION_SHIFT - 3))
                 + 29'(ioctl_addr[REGION_SHIFT-1:3]);
  assign w_match = r_asm_valid && (w_wa == r_asm_addr);

  // w_m* merges the lane into the current entry; w_n* starts a fresh entry.
  always_comb begin
    w_mdata = w_match ? r_asm_data : 64'd0;
    w_mbe   = w_match ? r_asm_be : 8'd0;
    w_ndata = 64'd0;
    w_nbe   = 8'd0;
    for (int k = 0; k < 4; k++) begin
      if (w_lane == 2'(k)) begin
        w_mdata[16*k +: 16] = ioctl_dout;
        w_mbe[2*k +: 2]     = 2'b11;
        w_ndata[16*k +: 16] = ioctl_dout;
        w_nbe[2*k +: 2]     = 2'b11;
      end
    end
  end

  always_comb begin
    w_push        = 1'b0;
    w_paddr       = r_asm_addr;
    w_pdata       = r_asm_data;
    w_pbe         = r_asm_be;
    w_asm_addr_n  = r_asm_addr;
    w_asm_data_n  = r_asm_data;
    w_asm_be_n    = r_asm_be;
    w_asm_valid_n = r_asm_valid;
    w_pend_n      = r_pend;
    if (r_pend) begin
      w_push = 1'b1;
      if (w_acc) begin
        w_asm_addr_n  = w_wa;
        w_asm_data_n  = w_ndata;
        w_asm_be_n    = w_nbe;
        w_asm_valid_n = 1'b1;
        w_pend_n      = w_lane3;
      end else begin
        w_asm_valid_n = 1'b0;
        w_pend_n      = 1'b0;
      end
    end else if (w_acc && r_asm_valid && !w_match) begin
      // Discontinuity: the old entry takes this cycle's push slot.
      w_push        = 1'b1;
      w_asm_addr_n  = w_wa;
      w_asm_data_n  = w_ndata;
      w_asm_be_n    = w_nbe;
      w_asm_valid_n = 1'b1;
      w_pend_n      = w_lane3;
    end else if (w_acc && w_lane3) begin
      w_push        = 1'b1;
      w_paddr       = w_wa;
      w_pdata       = w_mdata;
      w_pbe         = w_mbe;
      w_asm_valid_n = 1'b0;
    end else if (w_acc) begin
      w_asm_addr_n  = w_wa;
      w_asm_data_n  = w_mdata;
      w_asm_be_n    = w_mbe;
      w_asm_valid_n = 1'b1;
    end else if (r_asm_valid && (((r_state == S_LOAD) && w_fall) || (r_state == S_FLUSH))) begin
      w_push        = 1'b1;
      w_asm_valid_n = 1'b0;
    end
  end

  assign w_nempty = (r_count != '0);
  assign w_full   = (r_count == c_CW'(FIFO_DEPTH));
  assign w_pop    = w_nempty && !ddram_busy;
  assign w_wr_en  = w_push && (!w_full || w_pop);

  always_comb begin
    w_count_n = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_n = r_count + 1'b1;
      2'b01:   w_count_n = r_count - 1'b1;
      default: w_count_n = r_count;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_asm_addr  <= '0;
      r_asm_data  <= '0;
      r_asm_be    <= '0;
      r_asm_valid <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_asm_addr  <= w_asm_addr_n;
      r_asm_data  <= w_asm_data_n;
      r_asm_be    <= w_asm_be_n;
      r_asm_valid <= w_asm_valid_n;
      r_pend      <= w_pend_n;
      if (w_go) begin
        r_asm_valid <= 1'b0;
        r_pend      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_fa[r_wp] <= w_paddr;
        r_fd[r_wp] <= w_pdata;
        r_fb[r_wp] <= w_pbe;
        r_wp       <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= w_count_n;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dl        <= 1'b0;
      r_rise_held <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_dl   <= ioctl_download;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state     <= S_LOAD;
            r_rise_held <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_fall) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_rise) r_rise_held <= 1'b1;
          // Looking at next-cycle values lets load_done follow the last pop directly.
          if ((w_count_n == '0) && !w_pend_n && !w_asm_valid_n) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (w_rise) r_rise_held <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ioctl_wait     = (r_count >= c_CW'(FIFO_DEPTH - 2)) || r_pend || (r_state == S_FLUSH);
  assign ddram_we       = w_nempty;
  assign ddram_addr     = w_nempty ? r_fa[r_rp] : 29'd0;
  assign ddram_din      = w_nempty ? r_fd[r_rp] : 64'd0;
  assign ddram_be       = w_nempty ? r_fb[r_rp] : 8'd0;
  assign ddram_burstcnt = 4'd1;
  assign load_done      = r_done;

endmodule
`default_nettype wire
